// File: rtl/dsp_loop_fetch.sv
// DSP instruction fetch stage with branch redirect, decode stall and a
// hardware loop stack for zero-overhead nested loops.
module dsp_loop_fetch #(
    parameter int ADDR_W     = 10,
    parameter int INST_W     = 32,
    parameter int LOOP_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int RESET_PC   = 0,
    localparam int LVL_W     = $clog2(LOOP_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [INST_W-1:0] read_data,
    output logic [INST_W-1:0] instruction_out,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              stall,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              loop_start,
    input  logic [CNT_W-1:0]  loop_count,
    input  logic [ADDR_W-1:0] loop_end_addr,
    output logic [LVL_W-1:0]  loop_level,
    output logic              loop_overflow
);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              valid_reg, valid_next;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic              ovf_reg, ovf_next;

    logic [ADDR_W-1:0] stk_start [LOOP_DEPTH];
    logic [ADDR_W-1:0] stk_end   [LOOP_DEPTH];
    logic [CNT_W-1:0]  stk_count [LOOP_DEPTH];

    logic              accept, cmd_ok, do_jump, push_req, full, do_push, at_end;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] eff_start, eff_end;
    logic [CNT_W-1:0]  eff_count;
    logic              eff_valid;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_start, wr_end;
    logic [CNT_W-1:0]  wr_count;

    always_comb begin
        accept   = !stall;
        cmd_ok   = accept && valid_reg;
        do_jump  = cmd_ok && jump_flag;
        push_req = cmd_ok && loop_start && !jump_flag && (loop_count != '0);
        full     = (level_reg == LVL_W'(LOOP_DEPTH));
        do_push  = push_req && !full;
        top_idx  = IDX_W'(level_reg - 1'b1);

        // The entry being pushed is compared in the same cycle so that a
        // one-instruction body loops back without a bubble.
        if (do_push) begin
            eff_start = inst_addr_plus1();
            eff_end   = loop_end_addr;
            eff_count = loop_count;
        end else begin
            eff_start = stk_start[top_idx];
            eff_end   = stk_end[top_idx];
            eff_count = stk_count[top_idx];
        end
        eff_valid = do_push || (level_reg != '0);
        at_end    = accept && eff_valid && (pc_reg == eff_end);

        pc_next    = pc_reg + 1'b1;
        valid_next = 1'b1;
        level_next = level_reg;
        ovf_next   = ovf_reg || (push_req && full);
        wr_en      = 1'b0;
        wr_idx     = IDX_W'(level_reg);
        wr_start   = eff_start;
        wr_end     = eff_end;
        wr_count   = eff_count;

        if (do_jump) begin
            pc_next    = jump_addr;
            valid_next = 1'b0;
        end else if (at_end && (eff_count > CNT_W'(1))) begin
            pc_next  = eff_start;
            wr_en    = 1'b1;
            wr_count = eff_count - 1'b1;
            if (do_push) begin
                level_next = level_reg + 1'b1;
            end else begin
                wr_idx = top_idx;
            end
        end else if (at_end) begin
            if (!do_push) begin
                level_next = level_reg - 1'b1;
            end
        end else if (do_push) begin
            wr_en      = 1'b1;
            level_next = level_reg + 1'b1;
        end
    end

    function automatic logic [ADDR_W-1:0] inst_addr_plus1();
        return addr_reg + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg    <= ADDR_W'(RESET_PC);
            addr_reg  <= '0;
            valid_reg <= 1'b0;
            level_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
            if (accept) begin
                pc_reg    <= pc_next;
                addr_reg  <= pc_reg;
                valid_reg <= valid_next;
                level_reg <= level_next;
            end
        end
    end

    for (genvar gi = 0; gi < LOOP_DEPTH; gi++) begin : g_stack
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                stk_start[gi] <= '0;
                stk_end[gi]   <= '0;
                stk_count[gi] <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                stk_start[gi] <= wr_start;
                stk_end[gi]   <= wr_end;
                stk_count[gi] <= wr_count;
            end
        end
    end

    assign read_addr       = stall ? addr_reg : pc_reg;
    assign instruction_out = valid_reg ? read_data : '0;
    assign inst_valid      = valid_reg;
    assign inst_addr       = addr_reg;
    assign loop_level      = level_reg;
    assign loop_overflow   = ovf_reg;
endmodule

// File: tb/tb_dsp_loop_fetch.sv
// Randomised bench for dsp_loop_fetch: a program table drives decode-side
// controls and a queue-based loop model predicts every output each cycle.
module tb_dsp_loop_fetch;
    localparam int AW = 10, IW = 32, DEPTH = 2, CW = 16;
    localparam int LW = $clog2(DEPTH + 1);

    logic          clk = 1'b0, rst = 1'b0;
    logic [AW-1:0] read_addr, inst_addr, jump_addr = '0, loop_end_addr = '0;
    logic [IW-1:0] read_data = '0, instruction_out;
    logic          inst_valid, stall = 1'b0, jump_flag = 1'b0, loop_start = 1'b0, loop_overflow;
    logic [CW-1:0] loop_count = '0;
    logic [LW-1:0] loop_level;

    always #5 clk = ~clk;

    dsp_loop_fetch #(.ADDR_W(AW), .INST_W(IW), .LOOP_DEPTH(DEPTH), .CNT_W(CW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(read_data),
        .instruction_out(instruction_out), .inst_valid(inst_valid), .inst_addr(inst_addr),
        .stall(stall), .jump_flag(jump_flag), .jump_addr(jump_addr),
        .loop_start(loop_start), .loop_count(loop_count), .loop_end_addr(loop_end_addr),
        .loop_level(loop_level), .loop_overflow(loop_overflow)
    );

    logic [IW-1:0] mem [1 << AW];
    always @(posedge clk) read_data <= mem[read_addr];

    // program: per-address decode actions
    bit            jmp_en [1 << AW];
    logic [AW-1:0] jmp_tgt[1 << AW];
    bit            ls_en  [1 << AW];
    logic [CW-1:0] ls_cnt [1 << AW];
    logic [AW-1:0] ls_end [1 << AW];

    typedef struct { logic [AW-1:0] s; logic [AW-1:0] e; logic [CW-1:0] c; } ent_t;
    ent_t          stk[$];
    logic [AW-1:0] m_pc, m_addr;
    bit            m_valid, m_ovf;

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("inst_valid", 64'(inst_valid), 64'(m_valid));
        check("inst_addr", 64'(inst_addr), 64'(m_addr));
        check("instruction_out", 64'(instruction_out), m_valid ? 64'(mem[m_addr]) : 64'd0);
        check("loop_level", 64'(loop_level), 64'(stk.size()));
        check("loop_overflow", 64'(loop_overflow), 64'(m_ovf));
    endtask

    task automatic clear_prog();
        for (int i = 0; i < (1 << AW); i++) begin
            jmp_en[i] = 0; jmp_tgt[i] = '0; ls_en[i] = 0; ls_cnt[i] = '0; ls_end[i] = '0;
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_addr = '0; m_valid = 0; m_ovf = 0;
        stk.delete();
    endtask

    // Called from the negative edge; leaves the bench at the next negative edge.
    task automatic step(input bit st);
        bit jf, ps, nv;
        logic [AW-1:0] np;
        ent_t t;
        stall = st;
        jump_flag = jmp_en[m_addr]; jump_addr = jmp_tgt[m_addr];
        loop_start = ls_en[m_addr]; loop_count = ls_cnt[m_addr]; loop_end_addr = ls_end[m_addr];
        #1 check("read_addr", 64'(read_addr), st ? 64'(m_addr) : 64'(m_pc));
        @(posedge clk);
        if (!st) begin
            jf = m_valid && jmp_en[m_addr];
            ps = m_valid && ls_en[m_addr] && !jmp_en[m_addr] && (ls_cnt[m_addr] != 0);
            if (ps) begin
                if (stk.size() == DEPTH) m_ovf = 1;
                else stk.push_back('{s: m_addr + 10'd1, e: ls_end[m_addr], c: ls_cnt[m_addr]});
            end
            nv = 1; np = m_pc + 10'd1;
            if (jf) begin
                np = jmp_tgt[m_addr]; nv = 0;
            end else if (stk.size() > 0 && m_pc == stk[stk.size()-1].e) begin
                t = stk[stk.size()-1];
                if (t.c > 1) begin
                    np = t.s; t.c = t.c - 1'b1; stk[stk.size()-1] = t;
                end else begin
                    void'(stk.pop_back());
                end
            end
            m_addr = m_pc; m_valid = nv; m_pc = np;
        end
        @(negedge clk);
        check_outputs();
        if (!st && m_valid)
            $display("txn t=%0t addr=%0d data=%08h level=%0d ovf=%0d", $time, m_addr, mem[m_addr], stk.size(), m_ovf);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge.
    task automatic do_reset(input bit st);
        @(negedge clk);
        stall = st;
        #2 rst = 1'b0;
        #1 model_reset();
        check_outputs();
        check("reset_read_addr", 64'(read_addr), 64'd0);
        @(negedge clk); @(negedge clk);
        stall = 1'b0;
        rst = 1'b1;
    endtask

    task automatic run(input int n, input int stall_pct);
        for (int k = 0; k < n; k++) step($urandom_range(99) < stall_pct);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 | i;
        clear_prog();
        model_reset();
        #1 check_outputs();
        check("reset_read_addr", 64'(read_addr), 64'd0);

        // linear fetch across the address wrap
        do_reset(0);
        run(1030, 0);

        // taken jump 5 -> 40
        clear_prog();
        jmp_en[5] = 1; jmp_tgt[5] = 10'd40;
        jmp_en[6] = 1; jmp_tgt[6] = 10'd99;  // flushed slot: must be ignored
        do_reset(0);
        run(50, 0);

        // single loop, then reset mid-loop
        clear_prog();
        ls_en[10] = 1; ls_cnt[10] = 3; ls_end[10] = 10'd12;
        do_reset(0);
        run(30, 0);
        run(13, 0);
        do_reset(0);
        run(30, 20);

        // nested loops with a one-instruction inner body
        clear_prog();
        ls_en[20] = 1; ls_cnt[20] = 2; ls_end[20] = 10'd25;
        ls_en[21] = 1; ls_cnt[21] = 3; ls_end[21] = 10'd22;
        do_reset(0);
        run(40, 0);
        run(40, 30);

        // overflow with a depth-2 stack
        clear_prog();
        ls_en[30] = 1; ls_cnt[30] = 2; ls_end[30] = 10'd40;
        ls_en[31] = 1; ls_cnt[31] = 2; ls_end[31] = 10'd38;
        ls_en[32] = 1; ls_cnt[32] = 2; ls_end[32] = 10'd35;
        do_reset(0);
        run(60, 0);

        // directed stall of three cycles at address 7
        clear_prog();
        do_reset(0);
        for (int k = 0; k < 20 && !(m_valid && m_addr == 10'd7); k++) step(0);
        check("reach_addr7", 64'(inst_addr), 64'd7);
        for (int k = 0; k < 3; k++) step(1);
        check("stall_hold_data", 64'(instruction_out), 64'(mem[7]));
        step(0);
        check("stall_release_addr", 64'(inst_addr), 64'd8);

        // randomised programs with stalls, zero-count loop, jump at loop end
        for (int r = 0; r < 3; r++) begin
            clear_prog();
            ls_en[100] = 1; ls_cnt[100] = CW'($urandom_range(1, 4)); ls_end[100] = 10'd105;
            ls_en[101] = 1; ls_cnt[101] = CW'($urandom_range(0, 3)); ls_end[101] = 10'd102;
            jmp_en[110] = 1; jmp_tgt[110] = 10'd130;
            ls_en[130] = 1; ls_cnt[130] = 3; ls_end[130] = 10'd133;
            jmp_en[132] = 1; jmp_tgt[132] = 10'd140;
            ls_en[140] = 1; ls_cnt[140] = 0; ls_end[140] = 10'd141;
            ls_en[142] = 1; ls_cnt[142] = CW'($urandom_range(1, 3)); ls_end[142] = 10'd143;
            jmp_en[150] = 1; jmp_tgt[150] = 10'd100;
            do_reset(0);
            for (int k = 0; k < 100 && m_pc != 10'd100; k++) step(0);
            run(150, 30);
            do_reset(1);
            run(20, 30);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dsp_loop_fetch.md
# dsp_loop_fetch

Parametrised successor to the single-level DSP fetch stage. It issues instruction-memory addresses, presents fetched words to decode with a valid flag, and honours branch redirects and a decode-side stall. It adds a hardware loop stack of configurable depth for zero-overhead nested loops. It sits between the instruction memory bank and the DSP decode/branch logic.

## Interface
Parameters:
- ADDR_W, 10: instruction address width.
- INST_W, 32: instruction word width.
- LOOP_DEPTH, 4: loop stack entries (≥1).
- CNT_W, 16: loop iteration counter width.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- read_addr  out  ADDR_W  instruction memory address. Synchronous SRAM, 1-cycle read latency.
- read_data  in  INST_W  memory data for the previous cycle's read_addr.
- instruction_out  out  INST_W  read_data when inst_valid=1, else 0 (NOP).
- inst_valid  out  1  instruction_out is a real instruction.
- inst_addr  out  ADDR_W  address of instruction_out.
- stall  in  1  decode cannot accept; hold the current instruction.
- jump_flag  in  1  taken branch for the current instruction.
- jump_addr  in  ADDR_W  branch target.
- loop_start  in  1  current instruction opens a hardware loop.
- loop_count  in  CNT_W  iteration count for loop_start.
- loop_end_addr  in  ADDR_W  address of the last body instruction.
- loop_level  out  $clog2(LOOP_DEPTH+1)  occupied stack entries.
- loop_overflow  out  1  sticky: a push was attempted while the stack was full.

## Operation
- Registers: pc (next fetch address), inst_addr, inst_valid, and the stack. Each stack entry holds {start, end, count}.
- read_addr = stall ? inst_addr : pc. This is a combinational path from stall, so the memory re-reads the held address during a stall.
- An "accept" cycle is one with stall=0. Only accept cycles update state. jump_flag and loop_start are ignored when inst_valid=0 or stall=1.
- On accept: inst_addr <= pc, inst_valid <= 1, pc <= next_pc.
- next_pc priority:
  1. jump_flag: next_pc = jump_addr, inst_valid <= 0. This flushes the word fetched at pc, costing one bubble.
  2. Loop end: stack non-empty and pc == top.end.
     - If top.count > 1: next_pc = top.start, decrement top.count.
     - If top.count == 1: pop, next_pc = pc+1.
  3. Otherwise next_pc = pc+1, wrapping modulo 2^ADDR_W.
- Push on accepted loop_start with jump_flag=0. The new entry is {start = inst_addr+1, end = loop_end_addr, count = loop_count}.
- The loop-end compare in the push cycle uses the entry being pushed (bypass). This lets a one-instruction body (end = inst_addr+1) repeat with no bubble.
- loop_count == 0: no push; the body executes once.
- Push when loop_level == LOOP_DEPTH: no push, loop_overflow <= 1 until reset. Fetch continues linearly.
- Only the top entry is compared. Nested loops need outer.end > inner.end; with equal ends, the outer loop falls through after the inner pops.
- jump_flag does not modify the stack. Jumping out of a loop body is a software error.
- Loops are zero-overhead: loop-back happens at fetch, with no bubble.

## Timing
- Reset (rst=0, async):
  - pc = RESET_PC, inst_addr = 0, inst_valid = 0, instruction_out = 0.
  - Stack empty, loop_level = 0, loop_overflow = 0.
  - read_addr = RESET_PC.
- After rst is released, the first valid instruction (RESET_PC) appears one cycle after the first rising edge.
- Fetch-to-output latency is 1 cycle. Throughput is 1 instruction per cycle with no stall.
- Taken jump: 1 bubble (inst_valid=0). The target instruction is valid 2 cycles after the jump cycle.
- Stall: instruction_out, inst_addr, inst_valid, pc and stack hold for every stall cycle. Output resumes the next cycle after stall falls.
- Simultaneous loop end and jump_flag: the jump wins and the count is not decremented.
- Simultaneous push and pop (bypass, count 1): net level unchanged; the body runs once.
- Reset asserted mid-loop or mid-stall clears everything immediately. No partial state survives.

## Test plan
- Linear fetch: reset, RESET_PC=0, memory[i]=i. Required: inst_addr 0,1,2… and instruction_out 0,1,2… from the first cycle after reset; read_addr wraps 1023→0 with ADDR_W=10.
- Jump: jump_flag=1 at inst_addr=5, jump_addr=40. Required: next cycle inst_valid=0; following cycle inst_addr=40.
- Single loop: loop_start at inst_addr=10, loop_count=3, loop_end_addr=12. Required: sequence 11,12,11,12,11,12,13 with no bubbles; loop_level 1 during the loop, 0 after.
- Nested plus single-instruction body: outer loop at inst_addr=20 (count 2, end 25); inner loop at inst_addr=21 (count 3, end 22). Required: 22 executes 3× per outer pass, 21–25 repeat twice; loop_level peaks at 2.
- Overflow: LOOP_DEPTH=2, three nested loop_start. Required: loop_overflow=1 sticky, loop_level stays 2, third body runs once.
- Stall and reset: stall=1 for 3 cycles at inst_addr=7. Required: instruction_out holds mem[7] and read_addr=7; inst_addr=8 the cycle after release. Assert rst mid-loop. Required: loop_level=0, inst_valid=0 asynchronously.
